// File: rtl/entry_pkg.sv
// Shared definitions for the DRSSTC entry block: default sizes, register
// indices, ASCII digit bounds and the UART receiver state encoding.
package entry_pkg;

   localparam int CONF_PAR_MAX_DEF = 8;
   localparam int CONF_PAR_4_DEF   = 5;

   // Meaning of each configuration register in the shift chain.
   localparam int IDX_INT_PER  = 0;
   localparam int IDX_INT_ON   = 1;
   localparam int IDX_GEN_HALF = 2;
   localparam int IDX_FB_CNT   = 3;
   localparam int IDX_FB_TO    = 4;

   localparam logic [7:0] ASCII_0 = 8'h30;
   localparam logic [7:0] ASCII_9 = 8'h39;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

endpackage

// File: rtl/drsstc_entry_uart_rx.sv
// 8N1 UART receiver, LSB first. Emits the received byte with a one-clock
// valid pulse; bytes whose stop bit reads 0 are dropped as framing errors.
module uart_rx
   import entry_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   logic          rx_s1, rx_s2, rx_prev;
   uart_state_t   state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_next;
   logic [7:0]    shift, shift_next;
   logic          valid_next;

   // Two-flop synchronizer plus one delay stage for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b0;
         rx_s2   <= 1'b0;
         rx_prev <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value; blocking here would collapse the synchronizer chain.
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shift   <= '0;
         valid   <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_next;
         shift   <= shift_next;
         valid   <= valid_next;
      end
   end

   // Next-state logic: mid-bit sampling of start, data and stop bits.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned and infers a latch.
      state_next = state;
      cnt_next   = cnt + 1'b1;
      bit_next   = bit_idx;
      shift_next = shift;
      valid_next = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            bit_next = '0;
            if (rx_prev && !rx_s2) state_next = START;
         end
         START: begin
            if (cnt == HALF) begin
               cnt_next   = '0;
               state_next = rx_s2 ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == FULL) begin
               cnt_next   = '0;
               shift_next = {rx_s2, shift[7:1]};
               bit_next   = bit_idx + 1'b1;
               if (bit_idx == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            if (cnt == FULL) begin
               cnt_next   = '0;
               valid_next = rx_s2;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign data = shift;

endmodule

// File: rtl/drsstc_entry.sv
// DRSSTC driver control: UART-loaded configuration chain, interrupter,
// start oscillator and generator-to-feedback handover.
// Optional macro FB_INVERT_EN inverts the synchronized feedback on fb_out.
module drsstc_entry
   import entry_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int CONF_PAR_MAX = CONF_PAR_MAX_DEF,
   parameter int CONF_PAR_4   = CONF_PAR_4_DEF,
   parameter int UNIT         = 4,
   parameter int INT_UNIT     = 64
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   uart_data,
   output logic [CONF_PAR_4-1:0][CONF_PAR_MAX-1:0] sh_reg,
   output logic                                   gen_out,
   input  logic                                   fb_in,
   output logic                                   fb_out,
   output logic                                   sel_out,
   output logic                                   int_out
);

   localparam int IW = CONF_PAR_MAX + $clog2(INT_UNIT) + 1;
   localparam int GW = CONF_PAR_MAX + $clog2(UNIT) + 1;
   localparam int EW = CONF_PAR_MAX + 1;

   logic [7:0]          rx_byte;
   logic                rx_valid, is_digit;
   logic [IW-1:0]       per_new, on_new, per_len, on_len, int_cnt;
   logic                int_run;
   logic [GW-1:0]       half_len, to_len, gen_cnt, to_cnt;
   logic                phase;
   logic                fb_s1, fbs, fb_prev, fb_pol, fb_edge;
   logic [EW-1:0]       edge_need, edge_cnt;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (uart_data),
      .data  (rx_byte),
      .valid (rx_valid)
   );

   assign is_digit = rx_valid && (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);

   // Shift a newly received decimal digit into index 0 of the chain.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the configuration bank is reset like any other state so the coil always starts from the minimal setting.
      if (!rst_n) sh_reg <= '0;
      else if (is_digit)
         sh_reg <= {sh_reg[CONF_PAR_4-2:0], CONF_PAR_MAX'(rx_byte - ASCII_0)};
   end

   assign per_new   = (IW'(sh_reg[IDX_INT_PER]) + IW'(1)) * IW'(INT_UNIT);
   assign on_new    = (IW'(sh_reg[IDX_INT_ON]) + IW'(1)) * IW'(INT_UNIT);
   assign half_len  = (GW'(sh_reg[IDX_GEN_HALF]) + GW'(1)) * GW'(UNIT);
   assign to_len    = (GW'(sh_reg[IDX_FB_TO]) + GW'(1)) * GW'(UNIT);
   assign edge_need = EW'(sh_reg[IDX_FB_CNT]) + EW'(1);

   // Interrupter period counter; period and on-time are latched at each period start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_run <= 1'b0;
         int_cnt <= '0;
         per_len <= '0;
         on_len  <= '0;
      end else if (!int_run || int_cnt == per_len - 1'b1) begin
         int_run <= 1'b1;
         int_cnt <= '0;
         per_len <= per_new;
         on_len  <= on_new;
      end else begin
         int_cnt <= int_cnt + 1'b1;
      end
   end

   assign int_out = int_run && (int_cnt < on_len);

   // Start oscillator: toggles every half_len clocks, held in phase 0 outside a burst.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gen_cnt <= '0;
         phase   <= 1'b0;
      end else if (!int_out) begin
         gen_cnt <= '0;
         phase   <= 1'b0;
      end else if (gen_cnt >= half_len - 1'b1) begin
         gen_cnt <= '0;
         phase   <= ~phase;
      end else begin
         gen_cnt <= gen_cnt + 1'b1;
      end
   end

   assign gen_out = phase & int_out & ~sel_out;

   // Feedback synchronizer and previous-value register for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fb_s1   <= 1'b0;
         fbs     <= 1'b0;
         fb_prev <= 1'b0;
      end else begin
         fb_s1   <= fb_in;
         fbs     <= fb_s1;
         fb_prev <= fbs;
      end
   end

`ifdef FB_INVERT_EN
   assign fb_pol = ~fbs;
`else
   assign fb_pol = fbs;
`endif

   // Edges are polarity-independent, so detection uses the raw synchronized value.
   assign fb_edge = fbs ^ fb_prev;
   assign fb_out  = fb_pol & int_out;

   // Handover select: count edges, hand over at the threshold, fall back on timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         to_cnt   <= '0;
         sel_out  <= 1'b0;
      end else if (!int_out) begin
         edge_cnt <= '0;
         to_cnt   <= '0;
         sel_out  <= 1'b0;
      end else if (fb_edge) begin
         to_cnt <= '0;
         if (edge_cnt + 1'b1 >= edge_need) sel_out <= 1'b1;
         if (edge_cnt < edge_need) edge_cnt <= edge_cnt + 1'b1;
      end else if (to_cnt >= to_len - 1'b1) begin
         to_cnt   <= '0;
         edge_cnt <= '0;
         sel_out  <= 1'b0;
      end else begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_drsstc_entry.sv
// Self-checking bench for drsstc_entry: UART table vectors, random bytes
// against a digit-chain model, interrupter timing and one full handover burst.
module tb_drsstc_entry;

   localparam int CPB = 16;

`ifdef FB_INVERT_EN
   localparam bit FB_INV = 1'b1;
`else
   localparam bit FB_INV = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            uart_data = 1'b1;
   logic            fb_in = 1'b0;
   logic [4:0][7:0] sh_reg;
   logic            gen_out, fb_out, sel_out, int_out;

   int total = 0;
   int bad   = 0;
   int model[5];

   typedef struct {
      logic [7:0]  ch;
      logic        stop;
      logic [39:0] exp;
   } vec_t;

   vec_t vecs[11];

   drsstc_entry #(
      .CLKS_PER_BIT (16),
      .CONF_PAR_MAX (8),
      .CONF_PAR_4   (5),
      .UNIT         (4),
      .INT_UNIT     (64)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .uart_data (uart_data),
      .sh_reg    (sh_reg),
      .gen_out   (gen_out),
      .fb_in     (fb_in),
      .fb_out    (fb_out),
      .sel_out   (sel_out),
      .int_out   (int_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [39:0] model_pack();
      logic [39:0] r;
      for (int k = 0; k < 5; k++) r[k*8 +: 8] = 8'(model[k]);
      return r;
   endfunction

   task automatic model_push(input logic [7:0] ch, input logic stop);
      if (stop && ch >= 8'h30 && ch <= 8'h39) begin
         for (int k = 4; k > 0; k--) model[k] = model[k-1];
         model[0] = int'(ch) - 48;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_data = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_data = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_data = stop;
      repeat (CPB) @(negedge clk);
      uart_data = 1'b1;
      repeat (3 * CPB) @(negedge clk);
   endtask

   // Values listed by register index; sent highest index first so a0 lands in index 0.
   task automatic set_cfg(input int a0, input int a1, input int a2, input int a3, input int a4);
      int v[5];
      v = '{a0, a1, a2, a3, a4};
      for (int k = 4; k >= 0; k--) begin
         send_byte(8'(48 + v[k]), 1'b1);
         model_push(8'(48 + v[k]), 1'b1);
      end
      check("cfg_load", sh_reg, model_pack());
   endtask

   task automatic wait_int(input logic level, input int limit, input string name);
      int n = 0;
      while (int_out !== level && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, int_out, level);
   endtask

   task automatic check_const_high(input string name);
      int lows = 0;
      repeat (500) @(negedge clk);
      for (int i = 0; i < 700; i++) begin
         if (int_out !== 1'b1) lows++;
         @(negedge clk);
      end
      check(name, lows, 0);
   endtask

   initial begin : main
      logic [7:0] ch;
      logic       stop;
      int         hi, lo, lo_err;
      int         ierr, gerr, serr, ferr, ntog;
      logic       exp_sel, exp_gen, exp_fb;

      vecs[0]  = '{8'h37, 1'b1, 40'h00_00_00_00_07};
      vecs[1]  = '{8'h32, 1'b1, 40'h00_00_00_07_02};
      vecs[2]  = '{8'h34, 1'b1, 40'h00_00_07_02_04};
      vecs[3]  = '{8'h32, 1'b1, 40'h00_07_02_04_02};
      vecs[4]  = '{8'h34, 1'b1, 40'h07_02_04_02_04};
      vecs[5]  = '{8'h34, 1'b1, 40'h02_04_02_04_04};
      vecs[6]  = '{8'h35, 1'b1, 40'h04_02_04_04_05};
      vecs[7]  = '{8'h33, 1'b0, 40'h04_02_04_04_05};
      vecs[8]  = '{8'h41, 1'b1, 40'h04_02_04_04_05};
      vecs[9]  = '{8'h3A, 1'b1, 40'h04_02_04_04_05};
      vecs[10] = '{8'h2F, 1'b1, 40'h04_02_04_04_05};
      for (int k = 0; k < 5; k++) model[k] = 0;

      // Reset state, then first interrupter period right after release.
      repeat (3) @(negedge clk);
      check("rst_sh_reg", sh_reg, 40'h0);
      check("rst_int_out", int_out, 1'b0);
      check("rst_gen_out", gen_out, 1'b0);
      check("rst_sel_out", sel_out, 1'b0);
      check("rst_fb_out", fb_out, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("int_first_clk", int_out, 1'b1);
      repeat (10) @(negedge clk);

      // Table vectors: the example string, then framing error and non-digits.
      for (int i = 0; i < 11; i++) begin
         send_byte(vecs[i].ch, vecs[i].stop);
         model_push(vecs[i].ch, vecs[i].stop);
         check($sformatf("table_%0d", i), sh_reg, vecs[i].exp);
      end

      // Random bytes around the digit range, occasional bad stop bit.
      for (int i = 0; i < 12; i++) begin
         ch   = 8'($urandom_range(8'h2C, 8'h3D));
         stop = ($urandom_range(0, 3) != 0);
         send_byte(ch, stop);
         model_push(ch, stop);
         check($sformatf("rand_%0d_ch%0h_s%0d", i, ch, stop), sh_reg, model_pack());
      end

      // Asynchronous reset in the middle of a frame.
      uart_data = 1'b0;
      repeat (CPB) @(negedge clk);
      uart_data = 1'b1;
      repeat (3 * CPB + 5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midframe_rst_sh_reg", sh_reg, 40'h0);
      check("midframe_rst_outputs", {int_out, gen_out, sel_out, fb_out}, 4'b0000);
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      for (int k = 0; k < 5; k++) model[k] = 0;
      send_byte(8'h36, 1'b1);
      model_push(8'h36, 1'b1);
      check("post_reset_frame", sh_reg, 40'h00_00_00_00_06);

      // Interrupter: P = 10*64 = 640, T = 5*64 = 320.
      set_cfg(9, 4, 4, 2, 4);
      wait_int(1'b0, 2000, "int_low_seen");
      wait_int(1'b1, 2000, "int_rise_seen");
      hi = 0;
      while (int_out === 1'b1 && hi < 2000) begin
         hi++;
         @(negedge clk);
      end
      lo = 0;
      lo_err = 0;
      while (int_out === 1'b0 && lo < 2000) begin
         if (gen_out !== 1'b0 || sel_out !== 1'b0 || fb_out !== 1'b0) lo_err++;
         lo++;
         @(negedge clk);
      end
      check("int_on_time", hi, 320);
      check("int_off_time", lo, 320);
      check("outputs_gated_when_off", lo_err, 0);

      // One burst, cycle n from the first high sample: generator with H = 20,
      // fb toggles at n = 100, 110, 120 (3 edges needed), then a 20-clock timeout.
      ierr = 0; gerr = 0; serr = 0; ferr = 0;
      for (int n = 0; n <= 150; n++) begin
         exp_sel = (n >= 123 && n <= 142);
         exp_gen = (((n / 20) % 2) == 1) && !exp_sel;
         ntog    = int'(n - 2 >= 100) + int'(n - 2 >= 110) + int'(n - 2 >= 120);
         exp_fb  = ((ntog % 2) == 1) ^ FB_INV;
         if (int_out !== 1'b1) ierr++;
         if (gen_out !== exp_gen) gerr++;
         if (sel_out !== exp_sel) serr++;
         if (fb_out !== exp_fb) ferr++;
         if (n == 122) check("sel_before_3rd_edge", sel_out, 1'b0);
         if (n == 123) check("sel_after_3rd_edge", sel_out, 1'b1);
         if (n == 142) check("sel_last_before_timeout", sel_out, 1'b1);
         if (n == 143) check("sel_after_timeout", sel_out, 1'b0);
         if (n == 100 || n == 110 || n == 120) fb_in = ~fb_in;
         @(negedge clk);
      end
      check("burst_int_errors", ierr, 0);
      check("burst_gen_errors", gerr, 0);
      check("burst_sel_errors", serr, 0);
      check("burst_fb_out_errors", ferr, 0);

      // On-time longer than, then equal to, the period keeps int_out high.
      set_cfg(2, 5, 0, 0, 0);
      check_const_high("int_const_on_gt_per");
      set_cfg(3, 3, 0, 0, 0);
      check_const_high("int_const_on_eq_per");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/drsstc_entry.md
Name: drsstc_entry

Overview:
- Top-level control block for a DRSSTC (dual-resonant solid-state Tesla coil) driver.
- Receives ASCII decimal configuration digits over a UART line and holds five configuration registers.
- Generates an interrupter burst signal, a start-oscillator square wave, a gated feedback copy, and a generator/feedback select that hands drive over to resonant feedback once it is stable.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit.
- CONF_PAR_MAX, 8, width of each configuration register.
- CONF_PAR_4, 5, number of configuration registers (index 0..4).
- UNIT, 4, clk cycles per count unit for the generator and feedback timeout.
- INT_UNIT, 64, clk cycles per count unit for the interrupter.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- uart_data  input  1  UART RX, idle high, 8N1, LSB first; asynchronous (2-FF synchronized internally).
- sh_reg  output  [CONF_PAR_4][CONF_PAR_MAX]  configuration registers.
- gen_out  output  1  start-oscillator square wave, gated by int_out.
- fb_in  input  1  resonant current feedback, asynchronous (2-FF synchronized).
- fb_out  output  1  synchronized fb_in, gated by int_out.
- sel_out  output  1  0 = generator drives bridge, 1 = feedback drives bridge.
- int_out  output  1  interrupter burst enable.

Behaviour:
- Reset: rst_n low asynchronously clears all sh_reg entries, counters, the UART state machine, and all outputs to 0.
- UART receiver FSM states are IDLE, START, DATA, STOP.
  - IDLE → START on a synchronized falling edge.
  - START samples the line at CLKS_PER_BIT/2; if the sample is high, return to IDLE (glitch), otherwise go to DATA.
  - DATA samples 8 bits, each CLKS_PER_BIT apart, LSB first.
  - STOP samples one bit; if it is 1 the byte is valid, if it is 0 it is a framing error and the byte is discarded. Return to IDLE in either case.
- Byte decode:
  - A valid byte 0x30..0x39 ('0'..'9') shifts the chain one clk after STOP: sh_reg[k] <= sh_reg[k-1] for k = 4..1, and sh_reg[0] <= byte - 0x30, zero-extended.
  - All other bytes are ignored.
  - Example: "7242445" yields sh_reg = {5, 4, 4, 2, 4} for indices 0..4.
- Register meanings:
  - 0 is the interrupter period.
  - 1 is the interrupter on-time.
  - 2 is the generator half-period.
  - 3 is the number of feedback edges required before handover.
  - 4 is the feedback timeout.
- Interrupter:
  - Period P = (sh_reg[0]+1)*INT_UNIT clks; on-time T = (sh_reg[1]+1)*INT_UNIT clks.
  - int_out is 1 for the first min(T, P) clks of each period and 0 for the rest.
  - P and T are latched at each period start, so register updates take effect at the next period.
  - First period starts on the first clk after reset release.
- Generator:
  - Free-running toggle every H = (sh_reg[2]+1)*UNIT clks.
  - Counter and phase reset to 0 while int_out = 0.
  - gen_out = phase & int_out & ~sel_out.
- Feedback:
  - fbs = 2-FF synchronized fb_in. Edge = fbs differs from its previous value.
  - fb_out = fbs & int_out.
- Select:
  - sel_out = 0 whenever int_out = 0; the edge counter and timeout counter are cleared at that time.
  - While int_out = 1, count edges. On reaching sh_reg[3]+1 edges, sel_out = 1 on the next clk.
  - Timeout counter reloads on every edge. If (sh_reg[4]+1)*UNIT clks pass without an edge, sel_out = 0 and the edge count is cleared; re-handover needs a full edge count again.
- Simultaneous edge and timeout expiry: the edge wins.
- A register shift during a burst affects the select/generator thresholds immediately; the interrupter is only affected at the next period.

Optional Feature:
- Macro: FB_INVERT_EN.
- When defined, fbs is inverted before edge detection and output: fb_out = ~fbs & int_out. Edge counting is unchanged (edges are polarity-independent).
- When undefined, fb_out follows fbs as described in Behaviour.

Decomposition:
- Package entry_pkg holds:
  - CONF_PAR_MAX and CONF_PAR_4 defaults;
  - register index constants IDX_INT_PER, IDX_INT_ON, IDX_GEN_HALF, IDX_FB_CNT, IDX_FB_TO;
  - ASCII_0 / ASCII_9 constants;
  - the uart_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module, uart_rx, outputs byte[7:0] plus a one-clk valid pulse, with the framing check inside it.

Test Plan (CLKS_PER_BIT=16, UNIT=4, INT_UNIT=64):
- Assert rst_n low mid-frame → sh_reg all 0, all outputs 0; after release, the next clean frame is received normally.
- Send "7242445" → sh_reg[0..4] = 5, 4, 4, 2, 4.
- Send '3' with stop bit 0, then 'A' (0x41) → sh_reg unchanged.
- sh_reg[0]=9 and sh_reg[1]=4 → int_out high 320 clks, low 320 clks, period 640.
- sh_reg[1] ≥ sh_reg[0] → int_out constantly 1.
- In a burst with sh_reg[2]=4, no fb → gen_out toggles every 20 clks, sel_out=0.
- Then fb toggling every 10 clks with sh_reg[3]=2 → sel_out=1 after the 3rd edge and gen_out=0.
- Then stop fb with sh_reg[4]=4 → sel_out=0 after 20 clks with no edge.
